// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 streaming wrappers.
package aes_pkg;
   localparam int unsigned AES_BLOCK_W    = 128;
   localparam int unsigned AES128_LATENCY = 21;

   typedef logic [AES_BLOCK_W-1:0] aes_block_t;
endpackage

// File: rtl/aes_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of two.
module aes_sync_fifo
   import aes_pkg::*;
#(
   parameter int unsigned WIDTH = AES_BLOCK_W,
   parameter int unsigned DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/aes_128_stream_ctrl.sv
// Valid/ready wrapper around a fully pipelined, non-stallable AES-128 encrypt core:
// issue muxing, in-flight token pipe and a credit-protected result FIFO.
module aes_128_stream_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned LATENCY = AES128_LATENCY,
   parameter int unsigned DEPTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_state,
   input  logic [AES_BLOCK_W-1:0] in_key,
   output logic [AES_BLOCK_W-1:0] core_state,
   output logic [AES_BLOCK_W-1:0] core_key,
   input  logic [AES_BLOCK_W-1:0] core_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
   output logic                   busy
);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

   logic [LATENCY-1:0] tok;
   logic [CW-1:0]      inflight;
   logic [CW-1:0]      fifo_count;
   logic [CW:0]        outstanding;
   logic               fire;
   logic               capture;
   logic               fifo_full;
   logic               fifo_empty;
   aes_block_t         fifo_head;

   // Credit uses start-of-cycle occupancy only, keeping out_ready off the in_ready path.
   assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
   assign in_ready    = !rst && (outstanding < CREDIT_MAX);
   assign fire        = in_valid && in_ready;
   assign capture     = tok[LATENCY-1];

   assign core_state = fire ? in_state : '0;
   assign core_key   = fire ? in_key   : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         tok <= '0;
      end else begin
         tok[0] <= fire;
         for (int unsigned i = 1; i < LATENCY; i++) tok[i] <= tok[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                  inflight <= '0;
      else if (fire && !capture) inflight <= inflight + 1'b1;
      else if (!fire && capture) inflight <= inflight - 1'b1;
   end

   aes_sync_fifo #(
      .WIDTH (AES_BLOCK_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (capture),
      .push_data (core_out),
      .pop       (out_ready),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !rst && !fifo_empty;
   assign out_data  = fifo_head;
   assign busy      = !rst && ((inflight != '0) || !fifo_empty);

   a_capture_room:  assert property (@(posedge clk) disable iff (rst) !(capture && fifo_full));
   a_no_underflow:  assert property (@(posedge clk) disable iff (rst) !(capture && inflight == '0));
   a_credit_bound:  assert property (@(posedge clk) disable iff (rst) outstanding <= CREDIT_MAX);
endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// Bench for aes_128_stream_ctrl: behavioural pipelined AES core plus an in-order
// scoreboard and a cycle-level credit/latency model.
module tb_aes_128_stream_ctrl;
   localparam int unsigned LAT = 21;
   localparam int unsigned DEP = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state = '0;
   logic [127:0] in_key = '0;
   logic [127:0] core_state, core_key, core_out, out_data;
   logic         in_ready, out_valid, busy;

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   int unsigned  cyc = 0;

   logic [7:0]   sbox_t [256];
   logic [127:0] core_pipe [LAT];
   logic [127:0] exp_q [$];
   logic [127:0] got_q [$];
   int unsigned  got_cyc [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_128_stream_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .in_key     (in_key),
      .core_state (core_state),
      .core_key   (core_key),
      .core_out   (core_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse (a^254) then the affine map.
   task automatic init_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] a;
         logic [7:0] inv;
         a   = 8'(v);
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gmul(inv, a);
         sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rk [16];
      logic [7:0]   tmp [4];
      logic [7:0]   rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[127-8*i -: 8];
         s[i]  = pt[127-8*i -: 8] ^ rk[i];
      end
      for (int r = 1; r <= 10; r++) begin
         tmp[0] = sbox_t[rk[13]] ^ rc;
         tmp[1] = sbox_t[rk[14]];
         tmp[2] = sbox_t[rk[15]];
         tmp[3] = sbox_t[rk[12]];
         for (int i = 0; i < 4; i++) rk[i] ^= tmp[i];
         for (int i = 4; i < 16; i++) rk[i] ^= rk[i-4];
         rc = xt(rc);
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[4*c+w] = sbox_t[s[4*((c+w)%4)+w]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
               s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
            end
         end else begin
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] ^= rk[i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Non-stallable core: samples state/key every edge, result appears LAT edges later.
   always @(posedge clk) begin
      core_pipe[0] <= aes_ref(core_state, core_key);
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_out = core_pipe[LAT-1];

   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) exp_q.push_back(aes_ref(in_state, in_key));
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_wait busy=%0b required=0", busy);
      end
      tick();
      clear_sb();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_state  = rand128();
      in_key    = rand128();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({in_ready, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags ready/valid/busy=%b required=000", {in_ready, out_valid, busy});
         end
         checks++;
         if (core_state !== '0 || core_key !== '0) begin
            errors++;
            $display("FAIL reset_core_bus state=%h key=%h required=0", core_state, core_key);
         end
      end
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset ready=%b valid=%b busy=%b required 1/0/0", in_ready, out_valid, busy);
      end
      tick();
   endtask

   task automatic test_fips(input string name, input logic [127:0] key,
                            input logic [127:0] pt, input logic [127:0] ct);
      int unsigned lat = 1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = pt;
      in_key    = key;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || core_state !== pt || core_key !== key) begin
         errors++;
         $display("FAIL %s_issue ready=%b core_state=%h core_key=%h required 1/%h/%h",
                  name, in_ready, core_state, core_key, pt, key);
      end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
         @(negedge clk);
      end
      checks++;
      if (lat !== LAT + 1) begin
         errors++;
         $display("FAIL %s_latency got=%0d required=%0d", name, lat, LAT + 1);
      end
      checks++;
      if (out_data !== ct) begin
         errors++;
         $display("FAIL %s_data got=%h required=%h", name, out_data, ct);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_single out_valid=%b required=0", name, out_valid);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int unsigned drops = 0;
      int unsigned n = 0;
      int unsigned f;
      f = cyc;
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         in_state = rand128();
         in_key   = rand128();
         @(negedge clk);
         if (!in_ready) drops++;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (drops !== 0) begin
         errors++;
         $display("FAIL b2b_ready_drops got=%0d required=0", drops);
      end
      while (got_q.size() < 64 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (got_q.size() !== 64 || exp_q.size() !== 64) begin
         errors++;
         $display("FAIL b2b_count got=%0d accepted=%0d required=64", got_q.size(), exp_q.size());
      end
      if (got_q.size() > 0) begin
         checks++;
         if (got_cyc[0] !== f + LAT + 1) begin
            errors++;
            $display("FAIL b2b_first_cycle got=%0d required=%0d", got_cyc[0], f + LAT + 1);
         end
      end
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_data[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
         end
         if (i > 0) begin
            checks++;
            if (got_cyc[i] !== f + LAT + 1 + i) begin
               errors++;
               $display("FAIL b2b_cycle[%0d] got=%0d required=%0d", i, got_cyc[i], f + LAT + 1 + i);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic        fired;
      int unsigned n = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = rand128();
      in_key    = rand128();
      for (int c = 0; c < int'(DEP + LAT + 20); c++) begin
         @(negedge clk);
         fired = in_ready;
         tick();
         if (fired) begin
            in_state = rand128();
            in_key   = rand128();
         end
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full ready=%b valid=%b required 0/1", in_ready, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_head_stable[%0d] got=%h required=%h", k, out_data,
                     exp_q.size() > 0 ? exp_q[0] : 128'h0);
         end
         tick();
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() !== DEP || got_q.size() !== 0) begin
         errors++;
         $display("FAIL bp_fires got=%0d popped=%0d required=%0d/0", exp_q.size(), got_q.size(), DEP);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (got_q.size() < exp_q.size() && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (got_q.size() !== DEP) begin
         errors++;
         $display("FAIL bp_drain_count got=%0d required=%0d", got_q.size(), DEP);
      end
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_data[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_return got=%b required=1", in_ready);
      end
      tick();
   endtask

   // Release out_ready on the cycle the last block is captured, with n-1 already buffered.
   task automatic test_simul_push_pop(input int unsigned nblk);
      int unsigned f;
      int unsigned target;
      int unsigned n = 0;
      f = cyc;
      out_ready = 1'b0;
      for (int unsigned i = 0; i < nblk; i++) begin
         in_valid = 1'b1;
         in_state = rand128();
         in_key   = rand128();
         tick();
      end
      in_valid = 1'b0;
      target = f + nblk - 1 + LAT;
      while (cyc < target) tick();
      out_ready = 1'b1;
      while (got_q.size() < nblk && n < 200) begin
         tick();
         n++;
      end
      @(negedge clk);
      checks++;
      if (got_q.size() !== nblk || exp_q.size() !== nblk || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul%0d_count got=%0d accepted=%0d valid=%b required=%0d/%0d/0",
                  nblk, got_q.size(), exp_q.size(), out_valid, nblk, nblk);
      end
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i] || got_cyc[i] !== target + i) begin
            errors++;
            $display("FAIL simul%0d_item[%0d] got=%h@%0d required=%h@%0d",
                     nblk, i, got_q[i], got_cyc[i], exp_q[i], target + i);
         end
      end
      tick();
   endtask

   task automatic test_random();
      int unsigned fq [$];
      int unsigned n = 0;
      logic exp_ir, exp_ov, exp_busy;
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_state  = rand128();
         in_key    = rand128();
         @(negedge clk);
         exp_ir   = (fq.size() < DEP);
         exp_ov   = (fq.size() != 0) && (fq[0] + LAT + 1 <= cyc);
         exp_busy = (fq.size() != 0);
         checks++;
         if (in_ready !== exp_ir || out_valid !== exp_ov || busy !== exp_busy) begin
            errors++;
            $display("FAIL rand_flags@%0d ready/valid/busy=%b%b%b required=%b%b%b",
                     cyc, in_ready, out_valid, busy, exp_ir, exp_ov, exp_busy);
         end
         if (out_valid && out_ready && fq.size() != 0) void'(fq.pop_front());
         if (in_valid && in_ready) fq.push_back(cyc);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((got_q.size() < exp_q.size() || busy) && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (got_q.size() !== exp_q.size() || exp_q.size() == 0) begin
         errors++;
         $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_data[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int unsigned f;
      int unsigned stale = 0;
      f = cyc;
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         in_state = rand128();
         in_key   = rand128();
         tick();
      end
      in_valid = 1'b0;
      while (cyc < f + LAT + 5) tick();
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_prefill valid=%b busy=%b required 1/1", out_valid, busy);
      end
      rst       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_flags ready/valid/busy=%b required=000", {in_ready, out_valid, busy});
      end
      tick();
      rst = 1'b0;
      clear_sb();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid || busy) stale++;
         tick();
      end
      checks++;
      if (stale !== 0 || got_q.size() !== 0) begin
         errors++;
         $display("FAIL mid_stale cycles=%0d outputs=%0d required=0/0", stale, got_q.size());
      end
   endtask

   initial begin
      init_sbox();
      test_reset();
      test_fips("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      wait_idle();
      test_fips("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
      wait_idle();
      test_back_to_back();
      wait_idle();
      test_backpressure();
      wait_idle();
      test_simul_push_pop(2);
      wait_idle();
      test_simul_push_pop(DEP);
      wait_idle();
      test_random();
      wait_idle();
      test_reset_mid();
      test_fips("fips_c1_after_reset", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t required=finish before 200000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
